// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes,
// forwarding-select encoding and small combinational helpers.
package ex_mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b100;

  // Where an ALU operand comes from: register file, EX/MEM or MEM/WB
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  // Pick an operand according to a forwarding select
  function automatic logic [DATA_W-1:0] fwd_mux(
    input fwd_sel_t          sel,
    input logic [DATA_W-1:0] reg_val,
    input logic [DATA_W-1:0] exmem_val,
    input logic [DATA_W-1:0] memwb_val
  );
    case (sel)
      FWD_EXMEM: fwd_mux = exmem_val;
      FWD_MEMWB: fwd_mux = memwb_val;
      default:   fwd_mux = reg_val;
    endcase
  endfunction

  // ALU: add/sub wrap, slt is signed, unused codes produce zero
  function automatic logic [DATA_W-1:0] alu_eval(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    case (op)
      ALU_ADD: alu_eval = a + b;
      ALU_SUB: alu_eval = a - b;
      ALU_AND: alu_eval = a & b;
      ALU_OR:  alu_eval = a | b;
      ALU_SLT: alu_eval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_eval = '0;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Bus between the ID/EX register, the hazard unit, the write-back stage
// and the EX/MEM register. The stage itself uses the slave view.
interface ex_mem_stage_if;
  import ex_mem_stage_pkg::*;

  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] sign_extend;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic              reg_write;
  logic              alu_src;
  logic              reg_dst;
  logic              mem_write;
  logic              mem_read;
  logic              mem_to_reg;
  logic [OP_W-1:0]   alu_op;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;

  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_write_reg;
  logic              out_zero;
  logic              out_reg_write;
  logic              out_mem_write;
  logic              out_mem_read;
  logic              out_mem_to_reg;

  modport master (
    output stall, flush, data1, data2, sign_extend, rs, rt, rd,
           reg_write, alu_src, reg_dst, mem_write, mem_read, mem_to_reg,
           alu_op, wb_reg_write, wb_write_reg, wb_write_data,
    input  out_alu_result, out_store_data, out_write_reg, out_zero,
           out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg
  );

  modport slave (
    input  stall, flush, data1, data2, sign_extend, rs, rt, rd,
           reg_write, alu_src, reg_dst, mem_write, mem_read, mem_to_reg,
           alu_op, wb_reg_write, wb_write_reg, wb_write_data,
    output out_alu_result, out_store_data, out_write_reg, out_zero,
           out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg
  );

endinterface

// File: rtl/ex_mem_stage_forwarding_unit.sv
// Forwarding unit: decides, per operand, whether the newest value of
// rs/rt lives in EX/MEM, in MEM/WB, or still in the register file.
// Register $0 is never forwarded because it is hardwired to zero.
module forwarding_unit
  import ex_mem_stage_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_write_reg,
  output fwd_sel_t         fwd_a,
  output fwd_sel_t         fwd_b
);

  logic ex_valid;
  logic wb_valid;

  // EX/MEM is the younger producer, so it is checked before MEM/WB
  always_comb begin
    ex_valid = ex_reg_write && (ex_write_reg != '0);
    wb_valid = wb_reg_write && (wb_write_reg != '0);

    fwd_a = FWD_REG;
    if (ex_valid && (ex_write_reg == rs))
      fwd_a = FWD_EXMEM;
    else if (wb_valid && (wb_write_reg == rs))
      fwd_a = FWD_MEMWB;

    fwd_b = FWD_REG;
    if (ex_valid && (ex_write_reg == rt))
      fwd_b = FWD_EXMEM;
    else if (wb_valid && (wb_write_reg == rt))
      fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register. Operands are forwarded
// from this stage's own registered result or from the write-back bus,
// the ALU result and destination are computed and then registered for
// the memory stage. The hazard unit can hold (stall) or bubble (flush).
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ex_mem_stage_if.slave bus
);

  fwd_sel_t          fwd_a_sel;
  fwd_sel_t          fwd_b_sel;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [REG_W-1:0]  dest_reg;

  forwarding_unit u_forwarding_unit (
    .rs           (bus.rs),
    .rt           (bus.rt),
    .ex_reg_write (bus.out_reg_write),
    .ex_write_reg (bus.out_write_reg),
    .wb_reg_write (bus.wb_reg_write),
    .wb_write_reg (bus.wb_write_reg),
    .fwd_a        (fwd_a_sel),
    .fwd_b        (fwd_b_sel)
  );

  // Operand selection, ALU and destination choice; the store value is
  // always the forwarded Rt, never the immediate
  always_comb begin
    op_a       = fwd_mux(fwd_a_sel, bus.data1, bus.out_alu_result, bus.wb_write_data);
    fwd_b      = fwd_mux(fwd_b_sel, bus.data2, bus.out_alu_result, bus.wb_write_data);
    op_b       = bus.alu_src ? bus.sign_extend : fwd_b;
    alu_result = alu_eval(bus.alu_op, op_a, op_b);
    dest_reg   = bus.reg_dst ? bus.rd : bus.rt;
  end

  // EX/MEM register: reset > flush (bubble) > stall (hold) > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_alu_result <= '0;
      bus.out_store_data <= '0;
      bus.out_write_reg  <= '0;
      bus.out_zero       <= 1'b0;
      bus.out_reg_write  <= 1'b0;
      bus.out_mem_write  <= 1'b0;
      bus.out_mem_read   <= 1'b0;
      bus.out_mem_to_reg <= 1'b0;
    end else if (bus.flush) begin
      bus.out_alu_result <= '0;
      bus.out_store_data <= '0;
      bus.out_write_reg  <= '0;
      bus.out_zero       <= 1'b0;
      bus.out_reg_write  <= 1'b0;
      bus.out_mem_write  <= 1'b0;
      bus.out_mem_read   <= 1'b0;
      bus.out_mem_to_reg <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_alu_result <= alu_result;
      bus.out_store_data <= fwd_b;
      bus.out_write_reg  <= dest_reg;
      bus.out_zero       <= (alu_result == '0);
      bus.out_reg_write  <= bus.reg_write;
      bus.out_mem_write  <= bus.mem_write;
      bus.out_mem_read   <= bus.mem_read;
      bus.out_mem_to_reg <= bus.mem_to_reg;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios for reset, forwarding,
// the $0 guard, immediates/stores, ALU corners and stall/flush, followed
// by a random instruction stream checked against an architectural
// register-file model.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  typedef struct {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] val;
  } wr_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ex_mem_stage_if bus();

  ex_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.data1 = '0; bus.data2 = '0; bus.sign_extend = '0;
    bus.rs = '0; bus.rt = '0; bus.rd = '0;
    bus.reg_write = 0; bus.alu_src = 0; bus.reg_dst = 0;
    bus.mem_write = 0; bus.mem_read = 0; bus.mem_to_reg = 0;
    bus.alu_op = ALU_ADD;
    bus.wb_reg_write = 0; bus.wb_write_reg = '0; bus.wb_write_data = '0;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic alu_src, input logic reg_dst,
                               input logic reg_write);
    bus.alu_op = op; bus.rs = rs; bus.rt = rt; bus.rd = rd;
    bus.data1 = d1; bus.data2 = d2; bus.sign_extend = imm;
    bus.alu_src = alu_src; bus.reg_dst = reg_dst; bus.reg_write = reg_write;
    bus.mem_write = 0; bus.mem_read = 0; bus.mem_to_reg = 0;
    bus.wb_reg_write = 0; bus.wb_write_reg = '0; bus.wb_write_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_alu_result !== 32'd0) begin errors++; $display("[TB] FAIL reset_alu got=%h exp=0", bus.out_alu_result); end
    checks++; if (bus.out_reg_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_reg_write got=%b exp=0", bus.out_reg_write); end
    @(negedge clk); rst = 1'b0;
    applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1);
    bus.mem_write = 1; bus.mem_read = 1; bus.mem_to_reg = 1;
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd12) begin errors++; $display("[TB] FAIL load_before_reset got=%h exp=c", bus.out_alu_result); end
    // assert reset between edges: outputs must clear without a clock edge
    #2; rst = 1'b1; #1;
    checks++; if (bus.out_alu_result !== 32'd0 || bus.out_store_data !== 32'd0 || bus.out_write_reg !== 5'd0 || bus.out_zero !== 1'b0)
      begin errors++; $display("[TB] FAIL async_reset_data got=%h/%h/%0d/%b exp=0/0/0/0", bus.out_alu_result, bus.out_store_data, bus.out_write_reg, bus.out_zero); end
    checks++; if ({bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg} !== 4'b0000)
      begin errors++; $display("[TB] FAIL async_reset_ctrl got=%b%b%b%b exp=0000", bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg); end
    @(negedge clk); rst = 1'b0;
    applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd12) begin errors++; $display("[TB] FAIL post_reset_add got=%h exp=c", bus.out_alu_result); end
    checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_zero got=%b exp=0", bus.out_zero); end
    checks++; if (bus.out_write_reg !== 5'd3) begin errors++; $display("[TB] FAIL post_reset_dest got=%0d exp=3", bus.out_write_reg); end
  endtask

  task automatic test_forwarding();
    // add $3 = $1 + $2
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd30) begin errors++; $display("[TB] FAIL fwd_first_add got=%0d exp=30", bus.out_alu_result); end
    // sub $4 = $3 - $1, stale $3, MEM/WB also claims $3 = 99
    @(negedge clk);
    applyStimulus(ALU_SUB, 5'd3, 5'd1, 5'd4, 32'd0, 32'd10, 32'd0, 1'b0, 1'b1, 1'b1);
    bus.wb_reg_write = 1; bus.wb_write_reg = 5'd3; bus.wb_write_data = 32'd99;
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd20) begin errors++; $display("[TB] FAIL fwd_exmem_priority got=%0d exp=20", bus.out_alu_result); end
    checks++; if (bus.out_write_reg !== 5'd4) begin errors++; $display("[TB] FAIL fwd_dest got=%0d exp=4", bus.out_write_reg); end
    // MEM/WB-only forward of $5 = 7
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd5, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    bus.wb_reg_write = 1; bus.wb_write_reg = 5'd5; bus.wb_write_data = 32'd7;
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd7) begin errors++; $display("[TB] FAIL fwd_memwb got=%0d exp=7", bus.out_alu_result); end
  endtask

  task automatic test_zero_guard();
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd55, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd55 || bus.out_write_reg !== 5'd0 || bus.out_reg_write !== 1'b1)
      begin errors++; $display("[TB] FAIL zero_setup got=%0d/%0d/%b exp=55/0/1", bus.out_alu_result, bus.out_write_reg, bus.out_reg_write); end
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    bus.wb_reg_write = 1; bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'd66;
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd0) begin errors++; $display("[TB] FAIL zero_guard got=%0d exp=0", bus.out_alu_result); end
    checks++; if (bus.out_zero !== 1'b1) begin errors++; $display("[TB] FAIL zero_guard_flag got=%b exp=1", bus.out_zero); end
  endtask

  task automatic test_alu_src_store();
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd1, 5'd6, 5'd0, 32'd100, 32'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    bus.mem_write = 1;
    bus.wb_reg_write = 1; bus.wb_write_reg = 5'd6; bus.wb_write_data = 32'd42;
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd96) begin errors++; $display("[TB] FAIL sw_address got=%0d exp=96", bus.out_alu_result); end
    checks++; if (bus.out_store_data !== 32'd42) begin errors++; $display("[TB] FAIL sw_store_data got=%0d exp=42", bus.out_store_data); end
    checks++; if (bus.out_mem_write !== 1'b1 || bus.out_reg_write !== 1'b0)
      begin errors++; $display("[TB] FAIL sw_ctrl got=%b%b exp=10", bus.out_mem_write, bus.out_reg_write); end
  endtask

  task automatic test_alu_corners();
    @(negedge clk);
    applyStimulus(ALU_SLT, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd1) begin errors++; $display("[TB] FAIL slt_neg got=%0d exp=1", bus.out_alu_result); end
    @(negedge clk);
    applyStimulus(ALU_SLT, 5'd2, 5'd4, 5'd3, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd0) begin errors++; $display("[TB] FAIL slt_pos got=%0d exp=0", bus.out_alu_result); end
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd4, 5'd5, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd0 || bus.out_zero !== 1'b1)
      begin errors++; $display("[TB] FAIL add_wrap got=%h/%b exp=0/1", bus.out_alu_result, bus.out_zero); end
    @(negedge clk);
    applyStimulus(3'b111, 5'd6, 5'd1, 5'd8, 32'd123, 32'd456, 32'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd0 || bus.out_zero !== 1'b1)
      begin errors++; $display("[TB] FAIL op_111 got=%h/%b exp=0/1", bus.out_alu_result, bus.out_zero); end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1);
    bus.mem_read = 1; bus.mem_to_reg = 1;
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd3) begin errors++; $display("[TB] FAIL stall_setup got=%0d exp=3", bus.out_alu_result); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      applyStimulus(ALU_OR, 5'd11, 5'd12, 5'd13, 32'd100, 32'd200, 32'd0, 1'b0, 1'b1, 1'b0);
      bus.mem_write = 1; bus.stall = 1;
      @(posedge clk); #1;
      checks++; if (bus.out_alu_result !== 32'd3 || bus.out_write_reg !== 5'd9)
        begin errors++; $display("[TB] FAIL stall_hold_data cyc=%0d got=%0d/%0d exp=3/9", c, bus.out_alu_result, bus.out_write_reg); end
      checks++; if ({bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg} !== 4'b1011)
        begin errors++; $display("[TB] FAIL stall_hold_ctrl cyc=%0d got=%b%b%b%b exp=1011", c, bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg); end
    end
    // held EX/MEM contents still forward once the stall drops
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd9, 5'd0, 5'd10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    bus.stall = 0;
    @(posedge clk); #1;
    checks++; if (bus.out_alu_result !== 32'd3) begin errors++; $display("[TB] FAIL stall_forward got=%0d exp=3", bus.out_alu_result); end
    @(negedge clk);
    applyStimulus(ALU_ADD, 5'd1, 5'd2, 5'd14, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1);
    bus.mem_write = 1; bus.mem_read = 1; bus.mem_to_reg = 1;
    bus.stall = 1; bus.flush = 1;
    @(posedge clk); #1;
    checks++; if ({bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg} !== 4'b0000)
      begin errors++; $display("[TB] FAIL flush_ctrl got=%b%b%b%b exp=0000", bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg); end
    @(negedge clk);
    clear_inputs();
  endtask

  // Random program: expected results come from architectural register
  // values, while the DUT sees register-file reads that lag by the
  // pipeline depth and must forward to catch up.
  task automatic test_random_program();
    logic [31:0] arch [32];
    logic [31:0] rf   [32];
    wr_t         hist [$];
    logic [4:0]  rs, rt, rd, dst;
    logic [2:0]  op;
    logic        alu_src, reg_dst, reg_write, mem_write, mem_to_reg;
    logic [31:0] imm, a, b_reg, b, res;
    int          sa, sb;

    @(negedge clk); clear_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      arch[r] = (r == 0) ? 32'd0 : $urandom;
      rf[r]   = arch[r];
    end

    for (int i = 0; i < 400; i++) begin
      rs         = 5'($urandom_range(0, 7));
      rt         = 5'($urandom_range(0, 7));
      rd         = 5'($urandom_range(0, 7));
      op         = 3'($urandom_range(0, 7));
      alu_src    = 1'($urandom_range(0, 1));
      reg_dst    = 1'($urandom_range(0, 1));
      mem_write  = ($urandom_range(0, 3) == 0);
      reg_write  = mem_write ? 1'b0 : ($urandom_range(0, 4) != 0);
      mem_to_reg = 1'($urandom_range(0, 1));
      imm        = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));

      a     = arch[rs];
      b_reg = arch[rt];
      b     = alu_src ? imm : b_reg;
      sa    = a;
      sb    = b;
      case (op)
        3'd0:    res = a + b;
        3'd1:    res = a - b;
        3'd2:    res = a & b;
        3'd3:    res = a | b;
        3'd4:    res = (sa < sb) ? 32'd1 : 32'd0;
        default: res = 32'd0;
      endcase
      dst = reg_dst ? rd : rt;

      @(negedge clk);
      applyStimulus(op, rs, rt, rd, rf[rs], rf[rt], imm, alu_src, reg_dst, reg_write);
      bus.mem_write = mem_write; bus.mem_to_reg = mem_to_reg;
      if (i >= 2) begin
        bus.wb_reg_write  = hist[i-2].we;
        bus.wb_write_reg  = hist[i-2].dst;
        bus.wb_write_data = hist[i-2].val;
      end else begin
        bus.wb_reg_write  = 1'b0;
        bus.wb_write_reg  = 5'($urandom_range(0, 7));
        bus.wb_write_data = $urandom;
      end
      @(posedge clk); #1;

      checks++; if (bus.out_alu_result !== res) begin errors++; $display("[TB] FAIL rnd_alu i=%0d got=%h exp=%h", i, bus.out_alu_result, res); end
      checks++; if (bus.out_store_data !== b_reg) begin errors++; $display("[TB] FAIL rnd_store i=%0d got=%h exp=%h", i, bus.out_store_data, b_reg); end
      checks++; if (bus.out_write_reg !== dst) begin errors++; $display("[TB] FAIL rnd_dest i=%0d got=%0d exp=%0d", i, bus.out_write_reg, dst); end
      checks++; if (bus.out_zero !== (res == 32'd0)) begin errors++; $display("[TB] FAIL rnd_zero i=%0d got=%b exp=%b", i, bus.out_zero, (res == 32'd0)); end
      checks++; if ({bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg} !== {reg_write, mem_write, 1'b0, mem_to_reg})
        begin errors++; $display("[TB] FAIL rnd_ctrl i=%0d got=%b%b%b%b exp=%b%b0%b", i, bus.out_reg_write, bus.out_mem_write, bus.out_mem_read, bus.out_mem_to_reg, reg_write, mem_write, mem_to_reg); end

      hist.push_back('{we: reg_write, dst: dst, val: res});
      if (reg_write && dst != 5'd0) arch[dst] = res;
      if (i >= 2 && hist[i-2].we && hist[i-2].dst != 5'd0) rf[hist[i-2].dst] = hist[i-2].val;
    end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_zero_guard();
    test_alu_src_store();
    test_alu_corners();
    test_stall_flush();
    test_random_program();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline. Consumes the registered ID/EX outputs (operands, sign-extended immediate, Rs/Rt/Rd, control bits, 3-bit ALU operation) and resolves RAW hazards by forwarding from its own EX/MEM contents and from the MEM/WB write-back bus. Computes the ALU result, selects the destination register and registers everything for the MEM stage. Supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
- No parameters; widths fixed: data 32, register index 5, ALU op 3.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all EX/MEM registers
- flush  in  1  load a bubble: all control outputs 0
- data1, data2  in  32  ID/EX register-file operands (Rs, Rt)
- sign_extend  in  32  ID/EX immediate
- rs, rt, rd  in  5  ID/EX register indices
- reg_write, alu_src, reg_dst, mem_write, mem_read, mem_to_reg  in  1 each  ID/EX control bits
- alu_op  in  3  ALU operation
- wb_reg_write  in  1  MEM/WB write enable
- wb_write_reg  in  5  MEM/WB destination
- wb_write_data  in  32  MEM/WB write-back value
- out_alu_result  out  32  registered ALU result / memory address
- out_store_data  out  32  registered forwarded Rt value for sw
- out_write_reg  out  5  registered destination index
- out_zero  out  1  registered (ALU result == 0)
- out_reg_write, out_mem_write, out_mem_read, out_mem_to_reg  out  1 each  registered control bits

## Operation
- Forwarding, operand A (Rs): if out_reg_write and out_write_reg != 0 and out_write_reg == rs -> out_alu_result; else if wb_reg_write and wb_write_reg != 0 and wb_write_reg == rs -> wb_write_data; else data1. EX/MEM match has priority over MEM/WB.
- Operand B (Rt): same rule with rt/data2, giving fwd_b.
- ALU input B = alu_src ? sign_extend : fwd_b. out_store_data takes fwd_b (never the immediate).
- Destination = reg_dst ? rd : rt.
- ALU ops: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 0 or 1), 101-111 -> result 0. add/sub wrap modulo 2^32; no overflow detection.
- Register update priority at each rising edge: rst (async) > flush > stall > normal load.
  - flush: control outputs cleared; data outputs (alu_result, store_data, write_reg, zero) may take any value — verification checks only the control bits.
  - stall: every output holds; forwarding from the held EX/MEM contents stays valid.
- Load-use hazards are not detected here. The hazard unit stalls upstream and flushes this stage. An EX/MEM load forwards its address, so correct operation depends on that stall.

## Timing
- Reset: all outputs 0, immediately on rst assertion, independent of clk. rst asserted mid-operation discards in-flight contents; first load occurs at the first rising edge after deassertion.
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Forwarding and ALU are combinational within the cycle. Paths: EX/MEM register -> mux -> ALU -> EX/MEM register, and wb_write_data -> mux -> ALU -> EX/MEM register.
- stall and flush high together: flush wins.
- Back-to-back dependent instructions forward with zero bubbles, except loads.

## Structure
- Shared package: ALU op constants (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b100) and forwarding-select encoding (FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01).
- One sub-module, forwarding_unit: compares rs/rt against the EX/MEM and MEM/WB destinations and emits two 2-bit selects. The ALU and pipeline registers live in ex_mem_stage.

## Test plan
- Reset: rst=1 mid-cycle with registers loaded -> every output 0 without a clock edge. Release rst, then add with data1=5, data2=7 -> out_alu_result=12, out_zero=0.
- EX/MEM forward: add $3=$1+$2 (10+20), then sub $4=$3-$1 with stale data1=0 -> second result 20. Both EX/MEM and MEM/WB match $3 with wb_write_data=99 -> 20 (EX/MEM priority).
- $0 guard: out_write_reg=0, out_reg_write=1, out_alu_result=55, rs=0, data1=0 -> operand A = 0, not 55.
- alu_src/sw: alu_src=1, sign_extend=32'hFFFFFFFC, data1=100, alu_op=add, rt forwarded from MEM/WB = 42 -> out_alu_result=96, out_store_data=42.
- slt/wrap: slt with A=32'hFFFFFFFF, B=1 -> 1; add 32'hFFFFFFFF+1 -> 0 with out_zero=1; alu_op=3'b111 -> 0.
- stall/flush: stall=1 for 2 cycles -> outputs unchanged; stall=1 and flush=1 -> all control outputs 0 after the edge.
